// File: rtl/fp_result_display_if.sv
// fp_result_display_if
//   Valid/ready result bus between the FP adder output stage (master)
//   and the result display block (slave).
//   in_data  : 32-bit FP result word        (master -> slave)
//   in_valid : in_data is valid this cycle  (master -> slave)
//   in_ready : slave accepts in_data        (slave -> master)
interface fp_result_display_if;
    logic [31:0] in_data;
    logic        in_valid;
    logic        in_ready;

    modport master (
        output in_data,
        output in_valid,
        input  in_ready
    );

    modport slave (
        input  in_data,
        input  in_valid,
        output in_ready
    );
endinterface

// File: rtl/fp_result_display.sv
// fp_result_display
//   Holds the latest FP adder result and shows one selected byte of it as
//   two hex digits on a pair of 7-segment displays. A debounced push-button
//   steps the byte select (0..3, wrapping). LEDs show the one-hot byte select
//   and a flag that is set when a different value has been captured since the
//   last button press.
// Ports
//   clk          system clock, rising edge
//   rst          synchronous reset, active-low
//   bus          result handshake (slave side): in_data, in_valid, in_ready
//   freeze       1 = hold current value and refuse new results
//   noisy_level  raw asynchronous push-button level
//   leds         {new_flag, 3'b000, one-hot byte select}
//   an0,a0..g0   digit 0 (low nibble), anode + segments, active-low
//   an1,a1..g1   digit 1 (high nibble), anode + segments, active-low
module fp_result_display #(
    parameter int DB_LIMIT = 50000,
    parameter int DB_CNT_W = 16
) (
    input  logic                clk,
    input  logic                rst,
    fp_result_display_if.slave  bus,
    input  logic                freeze,
    input  logic                noisy_level,
    output logic [7:0]          leds,
    output logic                an0,
    output logic                a0, b0, c0, d0, e0, f0, g0,
    output logic                an1,
    output logic                a1, b1, c1, d1, e1, f1, g1
);

    localparam logic [DB_CNT_W-1:0] DB_LAST = DB_CNT_W'(DB_LIMIT - 1);

    logic [31:0]         held;
    logic [1:0]          sel;
    logic                new_flag;
    logic                sync_ff1;
    logic                sync_ff2;
    logic                db_level;
    logic                db_level_q;
    logic [DB_CNT_W-1:0] db_cnt;
    logic [6:0]          seg0_r;
    logic [6:0]          seg1_r;
    logic [7:0]          leds_r;

    logic                capture;
    logic                press;
    logic [7:0]          byte_shown;
    logic [3:0]          sel_onehot;

    // Active-low segment pattern, bit 6 = a ... bit 0 = g.
    function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
        logic [6:0] seg;
        seg = 7'b1111111;
        case (nib)
            4'h0: seg = 7'b0000001;
            4'h1: seg = 7'b1001111;
            4'h2: seg = 7'b0010010;
            4'h3: seg = 7'b0000110;
            4'h4: seg = 7'b1001100;
            4'h5: seg = 7'b0100100;
            4'h6: seg = 7'b0100000;
            4'h7: seg = 7'b0001111;
            4'h8: seg = 7'b0000000;
            4'h9: seg = 7'b0000100;
            4'hA: seg = 7'b0001000;
            4'hB: seg = 7'b1100000;
            4'hC: seg = 7'b0110001;
            4'hD: seg = 7'b1000010;
            4'hE: seg = 7'b0110000;
            4'hF: seg = 7'b0111000;
            default: seg = 7'b1111111;
        endcase
        return seg;
    endfunction

    assign bus.in_ready = ~freeze;
    assign capture      = bus.in_valid & ~freeze;
    // db_level_q lags db_level by one cycle, so this is high for exactly the
    // cycle after a 0->1 transition of the debounced level.
    assign press        = db_level & ~db_level_q;

    // Button synchroniser and debouncer. The count restarts whenever the
    // synchronised sample matches the accepted level.
    always_ff @(posedge clk) begin
        if (!rst) begin
            sync_ff1   <= 1'b0;
            sync_ff2   <= 1'b0;
            db_level   <= 1'b0;
            db_level_q <= 1'b0;
            db_cnt     <= '0;
        end else begin
            sync_ff1   <= noisy_level;
            sync_ff2   <= sync_ff1;
            db_level_q <= db_level;
            if (sync_ff2 == db_level) begin
                db_cnt <= '0;
            end else if (db_cnt == DB_LAST) begin
                db_level <= sync_ff2;
                db_cnt   <= '0;
            end else begin
                db_cnt <= db_cnt + 1'b1;
            end
        end
    end

    // Held value, byte select and new-value flag. A capture that sets the
    // flag takes priority over the clear from a press in the same cycle.
    always_ff @(posedge clk) begin
        if (!rst) begin
            held     <= '0;
            sel      <= '0;
            new_flag <= 1'b0;
        end else begin
            if (capture) begin
                held <= bus.in_data;
            end
            if (press) begin
                sel <= sel + 2'd1;
            end
            if (capture && (bus.in_data != held)) begin
                new_flag <= 1'b1;
            end else if (press) begin
                new_flag <= 1'b0;
            end
        end
    end

    always_comb begin
        byte_shown = held[{sel, 3'b000} +: 8];
        sel_onehot = 4'b0001 << sel;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            seg0_r <= 7'b0000001;
            seg1_r <= 7'b0000001;
            leds_r <= 8'h01;
        end else begin
            seg0_r <= hex_to_seg(byte_shown[3:0]);
            seg1_r <= hex_to_seg(byte_shown[7:4]);
            leds_r <= {new_flag, 3'b000, sel_onehot};
        end
    end

    // Both displays are always lit; there is no digit multiplexing.
    assign an0  = 1'b0;
    assign an1  = 1'b0;
    assign leds = leds_r;
    assign {a0, b0, c0, d0, e0, f0, g0} = seg0_r;
    assign {a1, b1, c1, d1, e1, f1, g1} = seg1_r;

endmodule

// File: tb/tb_fp_result_display.sv
module tb_fp_result_display;

    localparam int DB_LIMIT = 4;
    localparam int DB_CNT_W = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       freeze = 1'b0;
    logic       noisy_level = 1'b0;
    logic [7:0] leds;
    logic       an0, a0, b0, c0, d0, e0, f0, g0;
    logic       an1, a1, b1, c1, d1, e1, f1, g1;
    logic [6:0] seg0_act;
    logic [6:0] seg1_act;

    fp_result_display_if bus();

    fp_result_display #(
        .DB_LIMIT (DB_LIMIT),
        .DB_CNT_W (DB_CNT_W)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .bus         (bus),
        .freeze      (freeze),
        .noisy_level (noisy_level),
        .leds        (leds),
        .an0         (an0),
        .a0          (a0), .b0(b0), .c0(c0), .d0(d0), .e0(e0), .f0(f0), .g0(g0),
        .an1         (an1),
        .a1          (a1), .b1(b1), .c1(c1), .d1(d1), .e1(e1), .f1(f1), .g1(g1)
    );

    always #5 clk = ~clk;

    assign seg0_act = {a0, b0, c0, d0, e0, f0, g0};
    assign seg1_act = {a1, b1, c1, d1, e1, f1, g1};

    typedef enum int {OP_CAP, OP_PRESS, OP_GLITCH} op_e;

    typedef struct {
        string       name;
        op_e         op;
        logic [31:0] data;
        logic [3:0]  hi;
        logic [3:0]  lo;
        logic [7:0]  leds;
    } vec_t;

    typedef struct {
        string      name;
        logic [3:0] hi;
        logic [3:0] lo;
        logic [7:0] leds;
    } exp_t;

    exp_t       exp_q[$];
    logic [6:0] seg_tab [16];
    vec_t       vecs [7];
    int         n_cmp = 0;
    int         n_err = 0;

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic push_exp(input string nm, input logic [3:0] hi, input logic [3:0] lo,
                            input logic [7:0] l);
        exp_t e;
        e.name = nm;
        e.hi   = hi;
        e.lo   = lo;
        e.leds = l;
        exp_q.push_back(e);
    endtask

    task automatic check_disp();
        exp_t e;
        if (exp_q.size() == 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL scoreboard: got empty queue expected an entry");
        end else begin
            e = exp_q.pop_front();
            chk({e.name, "_digit1"}, {25'd0, seg1_act}, {25'd0, seg_tab[e.hi]});
            chk({e.name, "_digit0"}, {25'd0, seg0_act}, {25'd0, seg_tab[e.lo]});
            chk({e.name, "_leds"},   {24'd0, leds},     {24'd0, e.leds});
            chk({e.name, "_anodes"}, {30'd0, an1, an0}, 32'd0);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        seg_tab[0]  = 7'b0000001; seg_tab[1]  = 7'b1001111;
        seg_tab[2]  = 7'b0010010; seg_tab[3]  = 7'b0000110;
        seg_tab[4]  = 7'b1001100; seg_tab[5]  = 7'b0100100;
        seg_tab[6]  = 7'b0100000; seg_tab[7]  = 7'b0001111;
        seg_tab[8]  = 7'b0000000; seg_tab[9]  = 7'b0000100;
        seg_tab[10] = 7'b0001000; seg_tab[11] = 7'b1100000;
        seg_tab[12] = 7'b0110001; seg_tab[13] = 7'b1000010;
        seg_tab[14] = 7'b0110000; seg_tab[15] = 7'b0111000;

        vecs[0] = '{"cap_first", OP_CAP,    32'h6ba37d9f, 4'h9, 4'hF, 8'h81};
        vecs[1] = '{"glitch",    OP_GLITCH, 32'h0,        4'h9, 4'hF, 8'h81};
        vecs[2] = '{"press_1",   OP_PRESS,  32'h0,        4'h7, 4'hD, 8'h02};
        vecs[3] = '{"press_2",   OP_PRESS,  32'h0,        4'hA, 4'h3, 8'h04};
        vecs[4] = '{"press_3",   OP_PRESS,  32'h0,        4'h6, 4'hB, 8'h08};
        vecs[5] = '{"press_wrap",OP_PRESS,  32'h0,        4'h9, 4'hF, 8'h01};
        vecs[6] = '{"cap_same",  OP_CAP,    32'h6ba37d9f, 4'h9, 4'hF, 8'h01};

        bus.in_data  = 32'h0;
        bus.in_valid = 1'b0;

        // Reset state
        rst = 1'b0;
        tick(3);
        push_exp("reset", 4'h0, 4'h0, 8'h01);
        check_disp();
        chk("reset_in_ready", {31'd0, bus.in_ready}, 32'd1);
        rst = 1'b1;
        tick(1);

        // Table-driven captures, glitch and presses
        for (int i = 0; i < 7; i++) begin
            push_exp(vecs[i].name, vecs[i].hi, vecs[i].lo, vecs[i].leds);
            case (vecs[i].op)
                OP_CAP: begin
                    bus.in_data  = vecs[i].data;
                    bus.in_valid = 1'b1;
                    tick(1);
                    bus.in_valid = 1'b0;
                    tick(1);
                    check_disp();
                end
                OP_PRESS: begin
                    noisy_level = 1'b1;
                    tick(8);
                    check_disp();
                    noisy_level = 1'b0;
                    tick(8);
                end
                default: begin
                    noisy_level = 1'b1; tick(1);
                    noisy_level = 1'b0; tick(1);
                    noisy_level = 1'b1; tick(1);
                    noisy_level = 1'b0; tick(8);
                    check_disp();
                end
            endcase
        end

        // Freeze refuses a valid result, release captures it
        freeze       = 1'b1;
        bus.in_data  = 32'h12345678;
        bus.in_valid = 1'b1;
        #1;
        chk("frz_in_ready", {31'd0, bus.in_ready}, 32'd0);
        tick(3);
        push_exp("frz_hold", 4'h9, 4'hF, 8'h01);
        check_disp();
        freeze = 1'b0;
        #1;
        chk("unfrz_in_ready", {31'd0, bus.in_ready}, 32'd1);
        tick(1);
        bus.in_valid = 1'b0;
        tick(1);
        push_exp("unfrz_cap", 4'h7, 4'h8, 8'h82 - 8'h01);
        check_disp();

        // Capture of a new value in the same cycle as a press: flag set wins
        noisy_level = 1'b1;
        tick(6);
        bus.in_data  = 32'hA5C3E1F0;
        bus.in_valid = 1'b1;
        tick(1);
        bus.in_valid = 1'b0;
        tick(1);
        push_exp("cap_press", 4'hE, 4'h1, 8'h82);
        check_disp();
        noisy_level = 1'b0;
        tick(8);

        // Reset in the middle of a debounce discards the pending press
        noisy_level = 1'b1;
        tick(5);
        rst = 1'b0;
        tick(1);
        push_exp("rst_mid", 4'h0, 4'h0, 8'h01);
        check_disp();
        rst = 1'b1;
        tick(6);
        push_exp("rst_nopress", 4'h0, 4'h0, 8'h01);
        check_disp();
        tick(2);
        push_exp("rst_press", 4'h0, 4'h0, 8'h02);
        check_disp();
        noisy_level = 1'b0;
        tick(2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
